pipelined_alu: RTL and testbench

//  EX-stage ALU of the 5-stage RV32I pipeline. Selects operands through EX/MEM and
//  MEM/WB forwarding muxes and an immediate mux, then computes the arithmetic, logic,

---
 rtl/pipelined_alu.sv | 128 ++++++++++++
 tb/tb_pipelined_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// EX-stage ALU for the 5-stage RV32I pipeline: forwarding and immediate muxes feed
// a single-cycle ALU, and a registered copy of the result drives the EX/MEM boundary.
module pipelined_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] read_data1_in,
    input  logic [XLEN-1:0] read_data2_in,
    input  logic [XLEN-1:0] ex_mem_alu_result_in,
    input  logic [XLEN-1:0] mem_wb_result_in,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [5:0]      alu_control,
    input  logic [XLEN-1:0] imm_val_r,
    input  logic [4:0]      shamt,
    input  logic            alu_src,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] result_q
);

    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_SLL   = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_SLTU  = 6'd5;
    localparam logic [5:0] OP_XOR   = 6'd6;
    localparam logic [5:0] OP_SRL   = 6'd7;
    localparam logic [5:0] OP_SRA   = 6'd8;
    localparam logic [5:0] OP_OR    = 6'd9;
    localparam logic [5:0] OP_AND   = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SLTIU = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_ORI   = 6'd15;
    localparam logic [5:0] OP_ANDI  = 6'd16;
    localparam logic [5:0] OP_SLLI  = 6'd17;
    localparam logic [5:0] OP_SRLI  = 6'd18;
    localparam logic [5:0] OP_SRAI  = 6'd19;
    localparam logic [5:0] OP_LB    = 6'd20;
    localparam logic [5:0] OP_LH    = 6'd21;
    localparam logic [5:0] OP_LW    = 6'd22;
    localparam logic [5:0] OP_LBU   = 6'd23;
    localparam logic [5:0] OP_LHU   = 6'd24;
    localparam logic [5:0] OP_SB    = 6'd25;
    localparam logic [5:0] OP_SH    = 6'd26;
    localparam logic [5:0] OP_SW    = 6'd27;
    localparam logic [5:0] OP_BEQ   = 6'd28;
    localparam logic [5:0] OP_BNE   = 6'd29;
    localparam logic [5:0] OP_BLT   = 6'd30;
    localparam logic [5:0] OP_BGE   = 6'd31;
    localparam logic [5:0] OP_BLTU  = 6'd32;
    localparam logic [5:0] OP_BGEU  = 6'd33;
    localparam logic [5:0] OP_LUI   = 6'd34;

    localparam logic [XLEN-2:0] ZPAD = '0;

    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] result_d;

    // Encoding 11 falls back to the register-file value, same as 00.
    always_comb begin
        src1 = read_data1_in;
        unique case (forwardA)
            2'b10:   src1 = ex_mem_alu_result_in;
            2'b01:   src1 = mem_wb_result_in;
            default: src1 = read_data1_in;
        endcase

        src2 = read_data2_in;
        unique case (forwardB)
            2'b10:   src2 = ex_mem_alu_result_in;
            2'b01:   src2 = mem_wb_result_in;
            default: src2 = read_data2_in;
        endcase

        opb = alu_src ? imm_val_r : src2;
    end

    always_comb begin
        result = '0;
        case (alu_control)
            OP_ADD:   result = src1 + opb;
            OP_SUB:   result = src1 - opb;
            OP_SLL:   result = src1 << opb[4:0];
            OP_SLT:   result = {ZPAD, ($signed(src1) < $signed(opb))};
            OP_SLTU:  result = {ZPAD, (src1 < opb)};
            OP_XOR:   result = src1 ^ opb;
            OP_SRL:   result = src1 >> opb[4:0];
            OP_SRA:   result = XLEN'($signed(src1) >>> opb[4:0]);
            OP_OR:    result = src1 | opb;
            OP_AND:   result = src1 & opb;
            OP_ADDI:  result = src1 + imm_val_r;
            OP_SLTI:  result = {ZPAD, ($signed(src1) < $signed(imm_val_r))};
            OP_SLTIU: result = {ZPAD, (src1 < imm_val_r)};
            OP_XORI:  result = src1 ^ imm_val_r;
            OP_ORI:   result = src1 | imm_val_r;
            OP_ANDI:  result = src1 & imm_val_r;
            OP_SLLI:  result = src1 << shamt;
            OP_SRLI:  result = src1 >> shamt;
            OP_SRAI:  result = XLEN'($signed(src1) >>> shamt);
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:
                      result = src1 + imm_val_r;
            // Branch compares always use src2, never the immediate.
            OP_BEQ:   result = {ZPAD, (src1 == src2)};
            OP_BNE:   result = {ZPAD, (src1 != src2)};
            OP_BLT:   result = {ZPAD, ($signed(src1) < $signed(src2))};
            OP_BGE:   result = {ZPAD, ($signed(src1) >= $signed(src2))};
            OP_BLTU:  result = {ZPAD, (src1 < src2)};
            OP_BGEU:  result = {ZPAD, (src1 >= src2)};
            OP_LUI:   result = imm_val_r;
            default:  result = '0;
        endcase
    end

    always_comb begin
        result_d = rst ? '0 : result;
    end

    always_ff @(posedge clk) begin
        result_q <= result_d;
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed cases followed by randomized
// operations compared against an arithmetic reference model.
module tb_pipelined_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] read_data1_in;
    logic [31:0] read_data2_in;
    logic [31:0] ex_mem_alu_result_in;
    logic [31:0] mem_wb_result_in;
    logic [1:0]  forwardA;
    logic [1:0]  forwardB;
    logic [5:0]  alu_control;
    logic [31:0] imm_val_r;
    logic [4:0]  shamt;
    logic        alu_src;
    logic [31:0] result;
    logic [31:0] result_q;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipelined_alu dut (
        .clk                  (clk),
        .rst                  (rst),
        .read_data1_in        (read_data1_in),
        .read_data2_in        (read_data2_in),
        .ex_mem_alu_result_in (ex_mem_alu_result_in),
        .mem_wb_result_in     (mem_wb_result_in),
        .forwardA             (forwardA),
        .forwardB             (forwardB),
        .alu_control          (alu_control),
        .imm_val_r            (imm_val_r),
        .shamt                (shamt),
        .alu_src              (alu_src),
        .result               (result),
        .result_q             (result_q)
    );

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [31:0] exm, input logic [31:0] mwb);
        if (sel == 2'b10) return exm;
        if (sel == 2'b01) return mwb;
        return rf;
    endfunction

    // Signed less-than by biasing both operands into unsigned order.
    function automatic logic lt_s(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] sra(input logic [31:0] a, input int s);
        if (a[31]) return ~((~a) >> s);
        return a >> s;
    endfunction

    function automatic logic [31:0] model();
        logic [31:0] a, b2, ob;
        int code, s;
        a  = pick(forwardA, read_data1_in, ex_mem_alu_result_in, mem_wb_result_in);
        b2 = pick(forwardB, read_data2_in, ex_mem_alu_result_in, mem_wb_result_in);
        ob = alu_src ? imm_val_r : b2;
        code = int'(alu_control);
        s = int'(ob % 32);
        case (code) inside
            1:  return a + ob;
            2:  return a - ob;
            3:  return a << s;
            4:  return {31'b0, lt_s(a, ob)};
            5:  return {31'b0, a < ob};
            6:  return a ^ ob;
            7:  return a >> s;
            8:  return sra(a, s);
            9:  return a | ob;
            10: return a & ob;
            11: return a + imm_val_r;
            12: return {31'b0, lt_s(a, imm_val_r)};
            13: return {31'b0, a < imm_val_r};
            14: return a ^ imm_val_r;
            15: return a | imm_val_r;
            16: return a & imm_val_r;
            17: return a << int'(shamt);
            18: return a >> int'(shamt);
            19: return sra(a, int'(shamt));
            [20:27]: return a + imm_val_r;
            28: return {31'b0, a == b2};
            29: return {31'b0, a != b2};
            30: return {31'b0, lt_s(a, b2)};
            31: return {31'b0, !lt_s(a, b2)};
            32: return {31'b0, a < b2};
            33: return {31'b0, !(a < b2)};
            34: return imm_val_r;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exm,
                         input logic [31:0] mwb, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [5:0] ctl, input logic [31:0] imm, input logic [4:0] sh,
                         input logic src);
        read_data1_in = r1;  read_data2_in = r2;
        ex_mem_alu_result_in = exm;  mem_wb_result_in = mwb;
        forwardA = fa;  forwardB = fb;  alu_control = ctl;
        imm_val_r = imm;  shamt = sh;  alu_src = src;
    endtask

    // Called at a falling edge after inputs settle: checks result, then result_q after the edge.
    task automatic cycle_check(input string tag);
        logic [31:0] exp;
        #1;
        exp = model();
        chk({tag, "_comb"}, result, exp);
        @(posedge clk);
        #1;
        chk({tag, "_reg"}, result_q, rst ? 32'h0 : exp);
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h10, 32'h20, 32'h0, 32'h0, 2'b00, 2'b00, 6'd1, 32'h0, 5'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_q", result_q, 32'h0);
        chk("reset_comb_unaffected", result, 32'h30);

        @(negedge clk); rst = 1'b0;
        #1; chk("add_basic", result, 32'h30);
        cycle_check("add_basic_m");

        @(negedge clk);
        drive(32'h10, 32'h20, 32'h100, 32'h0, 2'b10, 2'b00, 6'd1, 32'h0, 5'd0, 1'b0);
        #1; chk("fwdA_exmem", result, 32'h120);
        cycle_check("fwdA_exmem_m");

        @(negedge clk);
        drive(32'h10, 32'h20, 32'h100, 32'h200, 2'b00, 2'b01, 6'd1, 32'h0, 5'd0, 1'b0);
        #1; chk("fwdB_memwb", result, 32'h210);

        @(negedge clk);
        drive(32'h10, 32'h20, 32'h100, 32'h200, 2'b00, 2'b00, 6'd11, 32'h5, 5'd0, 1'b1);
        #1; chk("addi", result, 32'h15);
        alu_control = 6'd17; shamt = 5'd2;
        #1; chk("slli", result, 32'h40);
        alu_src = 1'b0; alu_control = 6'd11;
        #1; chk("addi_ignores_alu_src", result, 32'h15);

        @(negedge clk);
        drive(32'h10, 32'h20, 32'h100, 32'h200, 2'b10, 2'b10, 6'd28, 32'h5, 5'd0, 1'b0);
        #1; chk("beq_same_fwd", result, 32'h1);
        alu_control = 6'd29;
        #1; chk("bne_same_fwd", result, 32'h0);
        alu_src = 1'b1; alu_control = 6'd28;
        #1; chk("beq_ignores_imm", result, 32'h1);

        @(negedge clk);
        drive(32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 2'b00, 2'b00, 6'd30, 32'h0, 5'd0, 1'b0);
        #1; chk("blt_signed", result, 32'h1);
        alu_control = 6'd32;
        #1; chk("bltu_unsigned", result, 32'h0);
        alu_control = 6'd8; read_data2_in = 32'h4;
        #1; chk("sra", result, 32'hFFFF_FFFF);
        read_data1_in = 32'h8000_0000;
        #1; chk("sra_sign", result, 32'hF800_0000);

        @(negedge clk);
        drive(32'h0, 32'h1, 32'h0, 32'h0, 2'b11, 2'b11, 6'd2, 32'h0, 5'd0, 1'b0);
        #1; chk("sub_wrap", result, 32'hFFFF_FFFF);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_clears_q", result_q, 32'h0);
        chk("rst_leaves_comb", result, 32'hFFFF_FFFF);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("q_after_rst", result_q, 32'hFFFF_FFFF);

        @(negedge clk);
        alu_control = 6'd63;
        #1; chk("code63", result, 32'h0);
        alu_control = 6'd0;
        #1; chk("code0", result, 32'h0);
        alu_control = 6'd34; imm_val_r = 32'hABCD_E000;
        #1; chk("lui", result, 32'hABCD_E000);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] r1, r2;
            @(negedge clk);
            rst = ($urandom_range(0, 15) == 0);
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 32'($urandom);
            drive(r1, r2, $urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  6'($urandom_range(0, 63)), $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)));
            cycle_check("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
